// File: rtl/thermal_ro_receiver.sv
// Counts ring-oscillator rising edges over a fixed window and decodes a bit by comparing against a latched threshold.
// Result strobe WINDOW_CYCLES+1 cycles after start; no backpressure, results hold until the next window completes.
module thermal_ro_receiver #(
  parameter int unsigned WINDOW_CYCLES = 65536,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk_main_a0,
  input  logic             rst_main_n,
  input  logic             ro_sense,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] threshold,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             bit_out,
  output logic [15:0]      meas_seq
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t           state;
  logic             ro_sync1;
  logic             ro_sync2;
  logic             ro_hist;
  logic             edge_pulse;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_cnt_next;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] thr_lat;

  assign edge_pulse = ro_sync2 & ~ro_hist;

  // Saturating increment; also feeds the final result so the last window cycle's edge is counted.
  always_comb begin
    edge_cnt_next = edge_cnt;
    if (edge_pulse && (edge_cnt != {CNT_W{1'b1}})) begin
      edge_cnt_next = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state      <= S_IDLE;
      ro_sync1   <= 1'b0;
      ro_sync2   <= 1'b0;
      ro_hist    <= 1'b0;
      edge_cnt   <= '0;
      win_cnt    <= '0;
      thr_lat    <= '0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      meas_count <= '0;
      bit_out    <= 1'b0;
      meas_seq   <= 16'd0;
    end else begin
      ro_sync1 <= ro_sense;
      ro_sync2 <= ro_sync1;
      ro_hist  <= ro_sync2;

      case (state)
        S_IDLE: begin
          meas_valid <= 1'b0;
          if (start && !abort) begin
            state    <= S_MEASURE;
            busy     <= 1'b1;
            edge_cnt <= '0;
            win_cnt  <= '0;
            thr_lat  <= threshold;
          end
        end

        S_MEASURE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            edge_cnt <= edge_cnt_next;
            win_cnt  <= win_cnt + WIN_W'(1);
            if (win_cnt == WIN_LAST) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              meas_valid <= 1'b1;
              meas_count <= edge_cnt_next;
              bit_out    <= (edge_cnt_next < thr_lat);
              meas_seq   <= meas_seq + 16'd1;
            end
          end
        end

        S_DONE: begin
          meas_valid <= 1'b0;
          if (start && !abort) begin
            state    <= S_MEASURE;
            busy     <= 1'b1;
            edge_cnt <= '0;
            win_cnt  <= '0;
            thr_lat  <= threshold;
          end else begin
            state <= S_IDLE;
          end
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          meas_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thermal_ro_receiver.sv
// Directed bench for thermal_ro_receiver with a 16-cycle window: table of measurements plus
// back-to-back, abort and mid-window reset sequences.
module tb_thermal_ro_receiver;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ro_sense = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] threshold = '0;
  logic          busy;
  logic          meas_valid;
  logic [CW-1:0] meas_count;
  logic          bit_out;
  logic [15:0]   meas_seq;

  int            total = 0;
  int            bad = 0;
  logic          ro_en = 1'b0;
  logic [1:0]    phase = 2'd0;
  logic [CW-1:0] thr_late = '0;
  logic [15:0]   exp_seq = 16'd0;

  typedef struct {
    logic [31:0] thr;
    logic [31:0] thr_after;
    logic        ro_on;
    logic [31:0] exp_cnt;
    logic        exp_bit;
  } vec_t;

  vec_t vecs[5];

  thermal_ro_receiver #(.WINDOW_CYCLES(W), .CNT_W(CW)) dut (
    .clk_main_a0(clk),
    .rst_main_n (rst_n),
    .ro_sense   (ro_sense),
    .start      (start),
    .abort      (abort),
    .threshold  (threshold),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_count (meas_count),
    .bit_out    (bit_out),
    .meas_seq   (meas_seq)
  );

  always #5 clk = ~clk;

  // RO model: period 4 clocks, 2 high / 2 low, driven away from the sampling edge.
  always @(negedge clk) begin
    phase = phase + 2'd1;
    ro_sense = ro_en & phase[1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ro(input logic on);
    if (ro_en != on) begin
      ro_en = on;
      repeat (8) @(negedge clk);
    end
  endtask

  // Start must already be high; returns the posedge count at which meas_valid is seen (0 = timeout).
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        threshold = thr_late;
      end
      if (meas_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic chk_result(input string tag, input int lat, input logic [31:0] cnt, input logic b);
    exp_seq = exp_seq + 16'd1;
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_count"}, meas_count, cnt);
    chk({tag, "_bit"}, {31'd0, bit_out}, {31'd0, b});
    chk({tag, "_seq"}, {16'd0, meas_seq}, {16'd0, exp_seq});
  endtask

  initial begin
    int lat;
    int nvalid;

    vecs[0] = '{32'd5, 32'd5, 1'b1, 32'd4, 1'b1};
    vecs[1] = '{32'd4, 32'd4, 1'b1, 32'd4, 1'b0};
    vecs[2] = '{32'd1, 32'd1, 1'b0, 32'd0, 1'b1};
    vecs[3] = '{32'd0, 32'd0, 1'b0, 32'd0, 1'b0};
    vecs[4] = '{32'd5, 32'd0, 1'b1, 32'd4, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, meas_valid}, 32'd0);
    chk("rst_count", meas_count, 32'd0);
    chk("rst_bit", {31'd0, bit_out}, 32'd0);
    chk("rst_seq", {16'd0, meas_seq}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      set_ro(vecs[i].ro_on);
      threshold = vecs[i].thr;
      thr_late = vecs[i].thr_after;
      start = 1'b1;
      wait_valid(lat);
      chk_result($sformatf("vec%0d", i), lat, vecs[i].exp_cnt, vecs[i].exp_bit);
      @(negedge clk);
      chk($sformatf("vec%0d_strobe_len", i), {31'd0, meas_valid}, 32'd0);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_hold_count", i), meas_count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_hold_bit", i), {31'd0, bit_out}, {31'd0, vecs[i].exp_bit});
    end

    // Back-to-back: restart in the DONE cycle.
    set_ro(1'b1);
    threshold = 32'd5;
    thr_late = 32'd5;
    start = 1'b1;
    wait_valid(lat);
    chk_result("b2b_first", lat, 32'd4, 1'b1);
    threshold = 32'd4;
    thr_late = 32'd4;
    start = 1'b1;
    wait_valid(lat);
    chk_result("b2b_second", lat, 32'd4, 1'b0);
    repeat (2) @(negedge clk);

    // Abort 8 cycles into MEASURE.
    threshold = 32'd9;
    thr_late = 32'd9;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_after", {31'd0, busy}, 32'd0);
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (meas_valid) nvalid++;
    end
    chk("abort_no_valid", nvalid, 0);
    chk("abort_count", meas_count, 32'd4);
    chk("abort_bit", {31'd0, bit_out}, 32'd0);
    chk("abort_seq", {16'd0, meas_seq}, {16'd0, exp_seq});

    // Abort and start together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a window.
    threshold = 32'd5;
    thr_late = 32'd5;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, meas_valid}, 32'd0);
    chk("midrst_count", meas_count, 32'd0);
    chk("midrst_bit", {31'd0, bit_out}, 32'd0);
    chk("midrst_seq", {16'd0, meas_seq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("first_edge_start", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (meas_valid) nvalid++;
    end
    chk("midrst_no_valid", nvalid, 0);
    exp_seq = 16'd0;
    threshold = 32'd5;
    thr_late = 32'd5;
    start = 1'b1;
    wait_valid(lat);
    chk_result("post_rst", lat, 32'd4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
